// File: rtl/pavana_scan_harness.sv
// Serial scan harness: an input chain shifted in and transferred to registered DUT inputs,
// and an output chain captured from DUT outputs and shifted out through a single tap.
module pavana_scan_harness #(
  parameter int IN_W      = 416,
  parameter int OUT_W     = 400,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shiftdata_i,
  input  logic             shift_en_i,
  input  logic             update_i,
  input  logic             rdcfg_i,
  input  logic [OUT_W-1:0] dut_out_i,
  output logic [IN_W-1:0]  dut_in_o,
  output logic             shiftdata_o,
  output logic             out_valid_o,
  output logic             in_full_o
);

  localparam int ICW = $clog2(IN_W + 1);
  localparam int OCW = $clog2(OUT_W + 1);

  localparam logic [ICW-1:0] IN_CNT_MAX  = ICW'(IN_W);
  localparam logic [OCW-1:0] OUT_CNT_MAX = OCW'(OUT_W);

  logic [IN_W-1:0]  in_chain_q,  in_chain_d;
  logic [IN_W-1:0]  dut_in_q,    dut_in_d;
  logic [ICW-1:0]   in_cnt_q,    in_cnt_d;
  logic [OUT_W-1:0] out_chain_q, out_chain_d;
  logic [OCW-1:0]   out_cnt_q,   out_cnt_d;

  always_comb begin
    in_chain_d = in_chain_q;
    dut_in_d   = dut_in_q;
    in_cnt_d   = in_cnt_q;

    if (shift_en_i) begin
      in_chain_d = {in_chain_q[IN_W-2:0], shiftdata_i};
    end

    // Update takes the chain as it was before this edge's shift.
    if (update_i) begin
      dut_in_d = in_chain_q;
      in_cnt_d = shift_en_i ? ICW'(1) : '0;
    end else if (shift_en_i && (in_cnt_q != IN_CNT_MAX)) begin
      in_cnt_d = in_cnt_q + ICW'(1);
    end
  end

  always_comb begin
    out_chain_d = out_chain_q;
    out_cnt_d   = out_cnt_q;

    if (rdcfg_i) begin
      out_chain_d = dut_out_i;
      out_cnt_d   = OUT_CNT_MAX;
    end else if (shift_en_i && (out_cnt_q != '0)) begin
      if (MSB_FIRST) begin
        out_chain_d = {out_chain_q[OUT_W-2:0], 1'b0};
      end else begin
        out_chain_d = {1'b0, out_chain_q[OUT_W-1:1]};
      end
      out_cnt_d = out_cnt_q - OCW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_chain_q  <= '0;
      dut_in_q    <= '0;
      in_cnt_q    <= '0;
      out_chain_q <= '0;
      out_cnt_q   <= '0;
    end else begin
      in_chain_q  <= in_chain_d;
      dut_in_q    <= dut_in_d;
      in_cnt_q    <= in_cnt_d;
      out_chain_q <= out_chain_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  // Outputs come straight from flops so nothing combinational reaches them from the inputs.
  assign dut_in_o    = dut_in_q;
  assign shiftdata_o = MSB_FIRST ? out_chain_q[OUT_W-1] : out_chain_q[0];
  assign out_valid_o = (out_cnt_q != '0);
  assign in_full_o   = (in_cnt_q == IN_CNT_MAX);

endmodule

// File: tb/tb_pavana_scan_harness.sv
// Directed bench: two 8-bit harnesses (LSB-first and MSB-first) plus one at default widths.
module tb_pavana_scan_harness;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sdi, shift_en, update, rdcfg;
  logic [7:0]   dut_out8;
  logic [399:0] dut_out_big;
  logic [7:0]   din_a, din_b;
  logic [415:0] din_big;
  logic sdo_a, sdo_b, sdo_big;
  logic val_a, val_b, val_big;
  logic full_a, full_b, full_big;

  int n_checks = 0;
  int n_pass   = 0;

  pavana_scan_harness #(.IN_W(8), .OUT_W(8), .MSB_FIRST(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .shiftdata_i(sdi), .shift_en_i(shift_en),
    .update_i(update), .rdcfg_i(rdcfg), .dut_out_i(dut_out8),
    .dut_in_o(din_a), .shiftdata_o(sdo_a), .out_valid_o(val_a), .in_full_o(full_a));

  pavana_scan_harness #(.IN_W(8), .OUT_W(8), .MSB_FIRST(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .shiftdata_i(sdi), .shift_en_i(shift_en),
    .update_i(update), .rdcfg_i(rdcfg), .dut_out_i(dut_out8),
    .dut_in_o(din_b), .shiftdata_o(sdo_b), .out_valid_o(val_b), .in_full_o(full_b));

  pavana_scan_harness dut_big (
    .clk_i(clk), .rst_i(rst), .shiftdata_i(sdi), .shift_en_i(shift_en),
    .update_i(update), .rdcfg_i(rdcfg), .dut_out_i(dut_out_big),
    .dut_in_o(din_big), .shiftdata_o(sdo_big), .out_valid_o(val_big), .in_full_o(full_big));

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled there as well.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; sdi = 0; shift_en = 0; update = 0; rdcfg = 0;
  endtask

  task automatic shift_bit(input logic b);
    sdi = b; shift_en = 1;
    tick();
    shift_en = 0; sdi = 0;
  endtask

  logic [7:0]   vec;
  logic [7:0]   got_a, got_b;
  logic [415:0] frame;
  logic [399:0] cap, got_big;

  initial begin
    idle();
    dut_out8 = '0;
    dut_out_big = '0;
    #2;

    // Reset with a capture and shift pending: reset must win.
    rst = 1; rdcfg = 1; shift_en = 1; dut_out8 = 8'hFF;
    tick();
    tick();
    idle();
    check("rst_din", din_a, 8'h00);
    check("rst_sdo", sdo_a, 1'b0);
    check("rst_valid", {val_a, val_b}, 2'b00);
    check("rst_full", {full_a, full_b}, 2'b00);

    // Shift in 1,0,1,1,0,0,1,0 -> B2
    vec = 8'b1011_0010;
    for (int k = 0; k < 8; k++) begin
      shift_bit(vec[7-k]);
      if (k == 6) check("full_after7", full_a, 1'b0);
    end
    check("full_after8", full_a, 1'b1);
    check("din_held_pre_update", din_a, 8'h00);
    update = 1;
    tick();
    update = 0;
    check("din_B2", din_a, 8'hB2);
    check("full_clr_update", full_a, 1'b0);

    // Capture A5 and shift out on both tap orders
    dut_out8 = 8'hA5; rdcfg = 1;
    tick();
    rdcfg = 0;
    got_a = '0; got_b = '0;
    for (int k = 0; k < 8; k++) begin
      got_a[k]   = sdo_a;
      got_b[7-k] = sdo_b;
      if (k == 7) check("valid_before8", {val_a, val_b}, 2'b11);
      shift_bit(1'b0);
    end
    check("lsb_first_A5", got_a, 8'hA5);
    check("msb_first_A5", got_b, 8'hA5);
    check("valid_fall", {val_a, val_b}, 2'b00);
    shift_bit(1'b0);
    check("sdo_hold_zero", {sdo_a, sdo_b}, 2'b00);
    check("valid_stays_low", {val_a, val_b}, 2'b00);

    // Load chain=0F, then capture+shift+update in one cycle
    vec = 8'h0F;
    for (int k = 0; k < 8; k++) shift_bit(vec[7-k]);
    dut_out8 = 8'h3C; rdcfg = 1; shift_en = 1; update = 1; sdi = 1;
    tick();
    idle();
    check("combo_din_0F", din_a, 8'h0F);
    check("combo_valid", {val_a, val_b}, 2'b11);
    check("combo_full", full_a, 1'b0);
    // in_cnt=1: seven further shifts fill the chain; out_cnt=8 keeps data flowing
    got_a = '0; got_b = '0;
    for (int k = 0; k < 7; k++) begin
      got_a[k]   = sdo_a;
      got_b[7-k] = sdo_b;
      if (k == 6) check("full_before7th", full_a, 1'b0);
      shift_bit(1'b0);
    end
    check("full_after7th", full_a, 1'b1);
    check("valid_last_bit", val_a, 1'b1);
    got_a[7] = sdo_a;
    got_b[0] = sdo_b;
    check("combo_out_lsb", got_a, 8'h3C);
    check("combo_out_msb", got_b, 8'h3C);
    update = 1;
    tick();
    update = 0;
    check("chain_1F_shifted", din_a, 8'h80);

    // Reset in the middle of an output shift
    dut_out8 = 8'hFF; rdcfg = 1;
    tick();
    rdcfg = 0;
    for (int k = 0; k < 3; k++) shift_bit(1'b1);
    check("mid_valid", val_a, 1'b1);
    rst = 1; shift_en = 1; update = 1; sdi = 1;
    tick();
    idle();
    check("mid_rst_sdo", {sdo_a, sdo_b}, 2'b00);
    check("mid_rst_valid", {val_a, val_b}, 2'b00);
    check("mid_rst_din", {din_a, din_b}, 16'h0000);
    got_a = '0;
    for (int k = 0; k < 5; k++) begin
      shift_bit(1'b1);
      got_a[k] = sdo_a | sdo_b;
    end
    check("post_rst_zero", got_a, 8'h00);

    // Default widths, random frames
    rst = 1;
    tick();
    idle();
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 13; w++) frame[w*32 +: 32] = $urandom;
      for (int w = 0; w < 13; w++) cap[w*32 +: 16] = 16'($urandom);
      for (int w = 0; w < 13; w++) cap[w*32+16 +: 16] = 16'($urandom);
      cap[399:384] = 16'($urandom);
      dut_out_big = cap;
      rdcfg = 1;
      tick();
      rdcfg = 0;
      got_big = '0;
      for (int k = 0; k < 416; k++) begin
        if (k < 400) got_big[k] = sdo_big;
        shift_bit(frame[415-k]);
      end
      check("big_full", full_big, 1'b1);
      check("big_valid_done", val_big, 1'b0);
      update = 1;
      tick();
      update = 0;
      check("big_din", din_big, frame);
      check("big_sout", got_big, cap);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
